axi_read_responder: RTL and testbench

- AXI4 read-channel responder (slave); the far end of the data/instruction cache AXI read masters.
- Backs an internal 64-bit-word memory array that can be preloaded through a side port.
- Serves one outstanding burst at a time (FIXED/INCR/WRAP) with a programmable first-beat latency.
- Used as the memory model in memory-stage and fetch benches, and as a simple on-chip ROM/RAM.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_burst_addr_gen.sv | 31 +++
 rtl/axi_read_responder.sv | 162 ++++++++++++++++
 tb/tb_axi_read_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI read-channel encodings, responder states and AR descriptor
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RESP_IDLE  = 2'd0,
        RESP_WAIT  = 2'd1,
        RESP_BURST = 2'd2
    } axi_resp_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_read_addr_struct;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next beat address for FIXED/INCR/WRAP plus WRAP length legality
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [63:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  burst_i,
    output logic [63:0] next_addr_o,
    output logic        wrap_len_ok_o
);

    logic [63:0] step;
    logic [63:0] wrap_bytes;
    logic [63:0] wrap_mask;

    // Beat step and wrap window; reserved burst encodings advance like INCR but are flagged elsewhere.
    always_comb begin
        step          = 64'd1 << size_i;
        wrap_bytes    = ({56'd0, len_i} + 64'd1) << size_i;
        wrap_mask     = wrap_bytes - 64'd1;
        wrap_len_ok_o = (len_i == 8'd1) || (len_i == 8'd3) ||
                        (len_i == 8'd7) || (len_i == 8'd15);
        case (burst_i)
            AXI_BURST_FIXED: next_addr_o = addr_i;
            AXI_BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);
            default:         next_addr_o = addr_i + step;
        endcase
    end

endmodule

// File: rtl/axi_read_responder.sv
// rtl/axi_read_responder.sv - single-outstanding AXI4 read responder backed by a preloadable word array
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int          DEPTH        = 4096,
    parameter logic [63:0] BASE_ADDR    = 64'h0,
    parameter int          READ_LATENCY = 2,
    localparam int         IDX_W        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_axi_arvalid,
    output logic             s_axi_arready,
    input  logic [63:0]      s_axi_araddr,
    input  logic [7:0]       s_axi_arlen,
    input  logic [2:0]       s_axi_arsize,
    input  logic [1:0]       s_axi_arburst,
    output logic             s_axi_rvalid,
    input  logic             s_axi_rready,
    output logic [63:0]      s_axi_rdata,
    output logic [1:0]       s_axi_rresp,
    output logic             s_axi_rlast,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_index,
    input  logic [63:0]      init_data,
    output logic             busy
);

    localparam logic [7:0]  LAT        = 8'(READ_LATENCY);
    localparam logic [63:0] DEPTH_WORDS = 64'(DEPTH);

    logic [63:0] mem [DEPTH];

    axi_resp_state_e     state_q, state_d;
    axi_read_addr_struct ar_q, ar_d;
    logic [7:0]          beat_q, beat_d;
    logic [7:0]          lat_q, lat_d;
    logic [63:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rlast_q, rlast_d;

    logic [63:0] next_addr;
    logic        wrap_len_ok;
    logic        burst_err;
    logic        load;
    logic        load_last;
    logic [63:0] load_addr;
    logic [63:0] word_off;
    logic        beat_err;
    logic [63:0] mem_word;

    axi_burst_addr_gen u_addr_gen (
        .addr_i        (ar_q.addr),
        .len_i         (ar_q.len),
        .size_i        (ar_q.size),
        .burst_i       (ar_q.burst),
        .next_addr_o   (next_addr),
        .wrap_len_ok_o (wrap_len_ok)
    );

    assign s_axi_arready = (state_q == RESP_IDLE) && reset;
    assign s_axi_rvalid  = (state_q == RESP_BURST);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign busy          = (state_q != RESP_IDLE);

    // Per-beat error: burst-wide illegal encodings plus the address of this particular beat.
    always_comb begin
        burst_err = (ar_q.size > 3'd3) || (ar_q.burst == AXI_BURST_RSVD) ||
                    ((ar_q.burst == AXI_BURST_WRAP) && !wrap_len_ok);
        word_off  = (load_addr - BASE_ADDR) >> 3;
        beat_err  = burst_err || (load_addr < BASE_ADDR) || (word_off >= DEPTH_WORDS);
        mem_word  = mem[word_off[IDX_W-1:0]];
    end

    // Next-state and beat-loading logic for IDLE -> WAIT -> BURST.
    always_comb begin
        state_d   = state_q;
        ar_d      = ar_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        load      = 1'b0;
        load_last = 1'b0;
        load_addr = ar_q.addr;
        case (state_q)
            RESP_IDLE: begin
                if (s_axi_arvalid) begin
                    ar_d    = '{addr: s_axi_araddr, len: s_axi_arlen,
                                size: s_axi_arsize, burst: s_axi_arburst};
                    beat_d  = 8'd0;
                    lat_d   = 8'd0;
                    state_d = RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                if (lat_q == LAT) begin
                    load      = 1'b1;
                    load_addr = ar_q.addr;
                    load_last = (ar_q.len == 8'd0);
                    state_d   = RESP_BURST;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            RESP_BURST: begin
                if (s_axi_rready) begin
                    if (beat_q == ar_q.len) begin
                        state_d = RESP_IDLE;
                        rdata_d = 64'd0;
                        rresp_d = AXI_RESP_OKAY;
                        rlast_d = 1'b0;
                    end else begin
                        beat_d     = beat_q + 8'd1;
                        ar_d.addr  = next_addr;
                        load       = 1'b1;
                        load_addr  = next_addr;
                        load_last  = ((beat_q + 8'd1) == ar_q.len);
                    end
                end
            end
            default: state_d = RESP_IDLE;
        endcase
        if (load) begin
            rdata_d = beat_err ? 64'd0 : mem_word;
            rresp_d = beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            rlast_d = load_last;
        end
    end

    // Control and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESP_IDLE;
            ar_q    <= '0;
            beat_q  <= 8'd0;
            lat_q   <= 8'd0;
            rdata_q <= 64'd0;
            rresp_q <= AXI_RESP_OKAY;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
        end
    end

    // Preload port; a beat loaded on the same edge samples the pre-write contents.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_index] <= init_data;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// tb/tb_axi_read_responder.sv - directed self-checking bench for axi_read_responder
module tb_axi_read_responder;
    import axi_pkg::*;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        init_we = 1'b0;
    logic [11:0] init_index = '0;
    logic [63:0] init_data = '0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_d[$];
    logic [1:0]  exp_r[$];

    axi_read_responder #(.DEPTH(DEPTH), .BASE_ADDR(64'h0), .READ_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .init_we(init_we), .init_index(init_index), .init_data(init_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [63:0] d);
        init_we = 1'b1; init_index = 12'(idx); init_data = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic issue_ar(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        int n = 0;
        araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
        while (!arready && n < 200) begin @(negedge clk); n++; end
        check("ar_accept", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        while (!rvalid && n < 300) begin @(negedge clk); n++; end
    endtask

    task automatic read_burst(input string tag);
        int n;
        int k = 0;
        logic [63:0] d;
        logic [1:0]  r;
        rready = 1'b1;
        wait_rvalid(n);
        while (exp_d.size() > 0) begin
            d = exp_d.pop_front();
            r = exp_r.pop_front();
            check($sformatf("%s_valid%0d", tag, k), rvalid, 1);
            check($sformatf("%s_data%0d", tag, k), rdata, d);
            check($sformatf("%s_resp%0d", tag, k), rresp, r);
            check($sformatf("%s_last%0d", tag, k), rlast, (exp_d.size() == 0));
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;

        #2;
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_arready", arready, 1);

        // single beat with latency measurement
        preload(4, 64'hDEADBEEF_00000004);
        rready = 1'b1;
        issue_ar(64'h20, 8'd0, 3'd3, AXI_BURST_INCR);
        check("single_busy", busy, 1);
        wait_rvalid(n);
        check("single_latency", n, 3);
        check("single_data", rdata, 64'hDEADBEEF_00000004);
        check("single_resp", rresp, AXI_RESP_OKAY);
        check("single_last", rlast, 1);
        @(negedge clk);
        check("single_rvalid_fall", rvalid, 0);
        check("single_arready_back", arready, 1);

        // cache-line INCR with rready alternating 0,1
        for (int i = 8; i < 16; i++) preload(i, 64'(i));
        rready = 1'b0;
        issue_ar(64'h40, 8'd7, 3'd3, AXI_BURST_INCR);
        wait_rvalid(n);
        for (int k = 0; k < 8; k++) begin
            rready = 1'b0;
            check($sformatf("incr_data%0d", k), rdata, 64'(8 + k));
            check($sformatf("incr_last%0d", k), rlast, (k == 7));
            @(negedge clk);
            check($sformatf("incr_hold%0d", k), rdata, 64'(8 + k));
            rready = 1'b1;
            @(negedge clk);
        end
        check("incr_done", rvalid, 0);

        // WRAP cache line starting mid-line
        for (int i = 0; i < 8; i++) preload(i, 64'(i));
        issue_ar(64'h28, 8'd7, 3'd3, AXI_BURST_WRAP);
        foreach (exp_d[i]) exp_d.delete();
        exp_d = '{64'd5, 64'd6, 64'd7, 64'd0, 64'd1, 64'd2, 64'd3, 64'd4};
        exp_r = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        read_burst("wrap");

        // out-of-range start address
        issue_ar(64'h8000, 8'd1, 3'd3, AXI_BURST_INCR);
        exp_d = '{64'd0, 64'd0};
        exp_r = '{AXI_RESP_SLVERR, AXI_RESP_SLVERR};
        read_burst("oob");

        // burst crossing the top of the array errors only on the outside beat
        preload(4095, 64'hCAFE_0FFF);
        issue_ar(64'h7FF8, 8'd1, 3'd3, AXI_BURST_INCR);
        exp_d = '{64'hCAFE_0FFF, 64'd0};
        exp_r = '{AXI_RESP_OKAY, AXI_RESP_SLVERR};
        read_burst("edge");

        // WRAP with illegal length
        issue_ar(64'h0, 8'd2, 3'd3, AXI_BURST_WRAP);
        exp_d = '{64'd0, 64'd0, 64'd0};
        exp_r = '{AXI_RESP_SLVERR, AXI_RESP_SLVERR, AXI_RESP_SLVERR};
        read_burst("wraplen");

        // oversize beat
        issue_ar(64'h0, 8'd0, 3'd4, AXI_BURST_INCR);
        exp_d = '{64'd0};
        exp_r = '{AXI_RESP_SLVERR};
        read_burst("size4");

        // reset during beat 3 of 8
        for (int i = 16; i < 24; i++) preload(i, 64'hA0 + 64'(i - 16));
        rready = 1'b1;
        issue_ar(64'h80, 8'd7, 3'd3, AXI_BURST_INCR);
        wait_rvalid(n);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_beat3", rdata, 64'hA2);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_rlast", rlast, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_arready", arready, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); seen = seen | rvalid; end
        check("rst_no_beats", seen, 0);
        issue_ar(64'h88, 8'd0, 3'd3, AXI_BURST_INCR);
        exp_d = '{64'hA1};
        exp_r = '{AXI_RESP_OKAY};
        read_burst("post_rst");

        // two ARs back to back
        preload(32, 64'h3200);
        preload(33, 64'h3300);
        preload(34, 64'h3400);
        rready = 1'b1;
        issue_ar(64'h100, 8'd1, 3'd3, AXI_BURST_INCR);
        araddr = 64'h110; arlen = 8'd0; arsize = 3'd3; arburst = AXI_BURST_INCR; arvalid = 1'b1;
        wait_rvalid(n);
        check("b2b_a_d0", rdata, 64'h3200);
        check("b2b_a_ar0", arready, 0);
        @(negedge clk);
        check("b2b_a_d1", rdata, 64'h3300);
        check("b2b_a_ar1", arready, 0);
        @(negedge clk);
        check("b2b_idle_arready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        exp_d = '{64'h3400};
        exp_r = '{AXI_RESP_OKAY};
        read_burst("b2b_b");

        // preload racing the beat load, then a preload while the beat is stalled
        preload(30, 64'h1111);
        rready = 1'b0;
        issue_ar(64'hF0, 8'd0, 3'd3, AXI_BURST_INCR);
        @(negedge clk);
        @(negedge clk);
        init_we = 1'b1; init_index = 12'd30; init_data = 64'h2222;
        @(negedge clk);
        init_we = 1'b0;
        check("race_rvalid", rvalid, 1);
        check("race_old", rdata, 64'h1111);
        preload(30, 64'h3333);
        check("race_held", rdata, 64'h1111);
        rready = 1'b1;
        @(negedge clk);
        check("race_done", rvalid, 0);
        issue_ar(64'hF0, 8'd0, 3'd3, AXI_BURST_INCR);
        exp_d = '{64'h3333};
        exp_r = '{AXI_RESP_OKAY};
        read_burst("reread");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
